// File: rtl/io_arbiter.sv
// -----------------------------------------------------------------------------
// io_arbiter
//
// Two-requester arbiter in front of a single IO port. One transaction is in
// flight at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Simultaneous
// requests are resolved round-robin. A transaction that sees no io_ok within
// TIMEOUT WAIT cycles is completed with an access-fault status.
//
// Parameters
//   TIMEOUT                  max WAIT cycles before forced completion (1..255)
//   EXCEPTION_LEN            width of the exception/status code
//   EXCEP_OK                 status code for a successful access
//   EXCEP_INVALID_MEM_READ   status code for a failed read
//   EXCEP_INVALID_MEM_WRITE  status code for a failed write
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mN_req                   requester N transaction request (N = 0, 1)
//   mN_addr/wdata/width      requester N payload
//   mN_isRead                requester N direction (1 = read)
//   mN_done                  one-cycle completion pulse to requester N
//   mN_rdata/mN_exception    completion data/status, non-zero only with mN_done
//   io_addr/data/width/isRead payload to the IO port, non-zero only in ISSUE
//   io_valid                 IO port inputValid, high for the ISSUE cycle
//   io_rdata, io_ok          IO port read data and operationOK
//   io_exception             IO port status, combinational from the io_* payload
//   busy                     high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module io_arbiter #(
    parameter int unsigned                  TIMEOUT                 = 15,
    parameter int unsigned                  EXCEPTION_LEN           = 4,
    parameter logic [EXCEPTION_LEN-1:0]     EXCEP_OK                = '0,
    parameter logic [EXCEPTION_LEN-1:0]     EXCEP_INVALID_MEM_READ  = EXCEPTION_LEN'(5),
    parameter logic [EXCEPTION_LEN-1:0]     EXCEP_INVALID_MEM_WRITE = EXCEPTION_LEN'(7)
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     m0_req,
    input  logic [31:0]              m0_addr,
    input  logic [31:0]              m0_wdata,
    input  logic [1:0]               m0_width,
    input  logic                     m0_isRead,
    output logic                     m0_done,
    output logic [31:0]              m0_rdata,
    output logic [EXCEPTION_LEN-1:0] m0_exception,

    input  logic                     m1_req,
    input  logic [31:0]              m1_addr,
    input  logic [31:0]              m1_wdata,
    input  logic [1:0]               m1_width,
    input  logic                     m1_isRead,
    output logic                     m1_done,
    output logic [31:0]              m1_rdata,
    output logic [EXCEPTION_LEN-1:0] m1_exception,

    output logic [31:0]              io_addr,
    output logic [31:0]              io_data,
    output logic [1:0]               io_width,
    output logic                     io_isRead,
    output logic                     io_valid,
    input  logic [31:0]              io_rdata,
    input  logic                     io_ok,
    input  logic [EXCEPTION_LEN-1:0] io_exception,

    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Last WAIT-cycle count value before the timeout fires.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                     r_state;
    logic                       r_owner;      // 0 = m0, 1 = m1
    logic                       r_last;       // last granted requester
    logic [31:0]                r_addr;
    logic [31:0]                r_wdata;
    logic [1:0]                 r_width;
    logic                       r_isRead;
    logic [EXCEPTION_LEN-1:0]   r_status;
    logic [7:0]                 r_cnt;

    logic                       r_io_valid;
    logic [31:0]                r_io_addr;
    logic [31:0]                r_io_data;
    logic [1:0]                 r_io_width;
    logic                       r_io_isRead;

    logic                       r_m0_done;
    logic [31:0]                r_m0_rdata;
    logic [EXCEPTION_LEN-1:0]   r_m0_exc;
    logic                       r_m1_done;
    logic [31:0]                r_m1_rdata;
    logic [EXCEPTION_LEN-1:0]   r_m1_exc;

    logic                       w_any;
    logic                       w_grant;
    logic [31:0]                w_addr;
    logic [31:0]                w_wdata;
    logic [1:0]                 w_width;
    logic                       w_isRead;
    logic                       w_fin;
    logic [31:0]                w_fin_rdata;
    logic [EXCEPTION_LEN-1:0]   w_fin_exc;

    // On a tie the requester not granted last wins; a sole requester always wins.
    assign w_any    = m0_req | m1_req;
    assign w_grant  = (m0_req & m1_req) ? ~r_last : m1_req;
    assign w_addr   = w_grant ? m1_addr   : m0_addr;
    assign w_wdata  = w_grant ? m1_wdata  : m0_wdata;
    assign w_width  = w_grant ? m1_width  : m0_width;
    assign w_isRead = w_grant ? m1_isRead : m0_isRead;

    // Completion in WAIT: io_ok takes priority over an expiring timeout.
    // Read data is only passed through for a read whose ISSUE status was OK.
    assign w_fin       = io_ok || (r_cnt == TO_LAST);
    assign w_fin_rdata = (io_ok && r_isRead && (r_status == EXCEP_OK)) ? io_rdata : 32'h0;
    assign w_fin_exc   = io_ok    ? r_status :
                         r_isRead ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_status    <= '0;
            r_cnt       <= '0;
            r_io_valid  <= 1'b0;
            r_io_addr   <= '0;
            r_io_data   <= '0;
            r_io_width  <= '0;
            r_io_isRead <= 1'b0;
            r_m0_done   <= 1'b0;
            r_m0_rdata  <= '0;
            r_m0_exc    <= '0;
            r_m1_done   <= 1'b0;
            r_m1_rdata  <= '0;
            r_m1_exc    <= '0;
        end else begin
            // Port-facing outputs are single-cycle: cleared unless set below.
            r_io_valid  <= 1'b0;
            r_io_addr   <= '0;
            r_io_data   <= '0;
            r_io_width  <= '0;
            r_io_isRead <= 1'b0;
            r_m0_done   <= 1'b0;
            r_m0_rdata  <= '0;
            r_m0_exc    <= '0;
            r_m1_done   <= 1'b0;
            r_m1_rdata  <= '0;
            r_m1_exc    <= '0;

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner     <= w_grant;
                        r_last      <= w_grant;
                        r_addr      <= w_addr;
                        r_wdata     <= w_wdata;
                        r_width     <= w_width;
                        r_isRead    <= w_isRead;
                        r_io_valid  <= 1'b1;
                        r_io_addr   <= w_addr;
                        r_io_data   <= w_wdata;
                        r_io_width  <= w_width;
                        r_io_isRead <= w_isRead;
                        r_state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    // A non-OK status still waits for the device's io_ok.
                    r_status <= io_exception;
                    r_cnt    <= '0;
                    r_state  <= WAIT;
                end

                WAIT: begin
                    if (w_fin) begin
                        r_status <= w_fin_exc;
                        if (r_owner) begin
                            r_m1_done  <= 1'b1;
                            r_m1_rdata <= w_fin_rdata;
                            r_m1_exc   <= w_fin_exc;
                        end else begin
                            r_m0_done  <= 1'b1;
                            r_m0_rdata <= w_fin_rdata;
                            r_m0_exc   <= w_fin_exc;
                        end
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_valid     = r_io_valid;
    assign io_addr      = r_io_addr;
    assign io_data      = r_io_data;
    assign io_width     = r_io_width;
    assign io_isRead    = r_io_isRead;

    assign m0_done      = r_m0_done;
    assign m0_rdata     = r_m0_rdata;
    assign m0_exception = r_m0_exc;
    assign m1_done      = r_m1_done;
    assign m1_rdata     = r_m1_rdata;
    assign m1_exception = r_m1_exc;

    assign busy         = (r_state != IDLE);

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, max WAIT-state cycles for io_ok before forced completion (1..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m0_req / m1_req  input  1  requester n transaction request.
REQ-005 mN_addr  input  32  requester n byte address.
REQ-006 mN_wdata  input  32  requester n write data.
REQ-007 mN_width  input  2  requester n access width, MEM_WIDTH_* encoding.
REQ-008 mN_isRead  input  1  requester n: 1 = read, 0 = write.
REQ-009 mN_done  output  1  one-cycle completion pulse to requester n.
REQ-010 mN_rdata  output  32  read data to requester n; valid only while mN_done=1.
REQ-011 mN_exception  output  EXCEPTION_LEN  completion status to requester n; valid only while mN_done=1.
REQ-012 io_addr / io_data  output  32 each  payload to IO port.
REQ-013 io_width  output  2  width to IO port.
REQ-014 io_isRead  output  1  direction to IO port.
REQ-015 io_valid  output  1  IO port inputValid.
REQ-016 io_rdata  input  32  IO port read data, registered by device.
REQ-017 io_ok  input  1  IO port operationOK, high the cycle after io_valid.
REQ-018 io_exception  input  EXCEPTION_LEN  IO port exception, combinational from io_valid/addr/width.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; requests are sampled only in IDLE.
REQ-021 IDLE: any mN_req high -> latch owner, addr, wdata, width, isRead; go ISSUE; no request -> stay IDLE.
REQ-022 Both requests high in IDLE -> grant the requester not granted last (round-robin); after reset m0 wins the first tie.
REQ-023 Last-granted pointer SHALL update only on grant; a sole requester is granted regardless of pointer.
REQ-024 ISSUE: io_valid=1 for exactly this cycle with latched payload on io_*; capture io_exception into status register; go WAIT.
REQ-025 Outside ISSUE io_valid=0; io_addr/io_data/io_width/io_isRead SHALL be 0.
REQ-026 WAIT: io_ok=1 -> capture io_rdata (forced 0 if write or captured status non-OK) and go DONE.
REQ-027 WAIT: timeout counter starts at 0 on WAIT entry, increments each WAIT cycle without io_ok; reaching TIMEOUT -> go DONE, status = EXCEP_INVALID_MEM_READ if read else EXCEP_INVALID_MEM_WRITE, rdata 0.
REQ-028 io_ok and timeout in same cycle -> io_ok wins.
REQ-029 Non-OK io_exception in ISSUE SHALL still proceed to WAIT (device still returns io_ok); status reported at DONE.
REQ-030 DONE: owner's mN_done=1, mN_rdata/mN_exception from registers; non-owner outputs 0; next state IDLE.
REQ-031 Nominal latency: req first high in cycle N -> ISSUE N+1 -> WAIT N+2 -> done pulse N+3 -> IDLE N+4; throughput one transaction per 4 cycles.
REQ-032 Requester SHALL hold req and payload stable until done, and drop req in the done cycle; req dropped early does not cancel the latched transaction, done still pulses.
REQ-033 io_ok high outside WAIT SHALL be ignored.
REQ-034 mN_done, mN_rdata, mN_exception SHALL be 0 whenever not in DONE for that owner.

Reset
REQ-035 rst=1 at edge -> state IDLE, io_valid 0, all done 0, rdata/exception/status registers 0, timeout counter 0, last-granted pointer = m1.
REQ-036 Reset mid-transaction SHALL abandon it silently: no done pulse issued for it.
REQ-037 First cycle after reset deassertion SHALL accept requests.

Verification
REQ-038 m0 read addr 0x0, width WORD, io_rdata=0xDEADBEEF, io_ok N+2 -> io_valid only N+1, m0_done N+3, m0_rdata 0xDEADBEEF, status EXCEP_OK.
REQ-039 m0 and m1 both req in IDLE after reset, repeated 3 times -> grant order m0, m1, m0; done pulses at N+3, N+7, N+11.
REQ-040 m1 write addr 0x8 (io_exception=EXCEP_INVALID_MEM_WRITE in ISSUE) -> m1_done with EXCEP_INVALID_MEM_WRITE, m1_rdata 0.
REQ-041 TIMEOUT=3, io_ok never asserted on a read -> m0_done at 3 WAIT cycles + 1, EXCEP_INVALID_MEM_READ, rdata 0, then IDLE.
REQ-042 rst asserted in WAIT -> next cycle IDLE, no done pulse; new m1 req after reset served with nominal latency.
REQ-043 io_ok pulsed in IDLE/DONE, m0 req dropped in ISSUE -> stray io_ok ignored; m0_done still pulses once.
